sensor_frame_tx: RTL and testbench

- Sensor-side transmitter for the two-byte keyed UART frame consumed by the board's frame receiver/arbiter.
- Serialises a data frame (value, then value XOR KEY) or an alarm frame onto a single 8N1 UART line.
- Sits between the sensor sampling logic and the tx pin; the internal serialiser and baud counter are self-contained, with no separate UART instance.

---
 rtl/sensor_frame_tx.sv | 207 ++++++++++++++++++++
 tb/tb_sensor_frame_tx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_tx.sv
// sensor_frame_tx
//   Sensor-side transmitter for the two-byte keyed UART frame. A data frame
//   is {value, value ^ KEY}. An alarm frame is {ALARM_TAG, ALARM_TAG, KEY}.
//   Each byte is sent as 8N1 and followed by GAP_BITS idle-high bit periods.
//   The serialiser and the baud counter are built in.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   sensor_data  value to send; sampled on the cycle send is accepted
//   send         single-cycle request for a data frame
//   alarm        single-cycle request for an alarm frame
//   tx           UART line, idle high
//   busy         high while a frame is in progress
//   done         one-cycle pulse when a frame completes
//   reject       one-cycle pulse when a send is refused
module sensor_frame_tx #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [7:0]  KEY       = 8'h37,
  parameter logic [7:0]  ALARM_TAG = 8'hFF,
  parameter int unsigned GAP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sensor_data,
  input  logic       send,
  input  logic       alarm,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       reject
);

  localparam int unsigned DIV       = CLK_HZ / BAUD;
  localparam int unsigned CW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [3:0]    GAP_LAST  = (GAP_BITS == 0) ? 4'd0 : 4'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;      // data bit index, reused as gap bit index
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          afr_q, afr_d;      // current frame is an alarm frame
  logic          pend_q, pend_d;    // alarm_pending
  logic          reject_q, reject_d;

  logic       bit_end;
  logic       byte_end;
  logic       last_byte;
  logic [1:0] next_idx;

  // Byte `idx` of the current frame.
  function automatic logic [7:0] frame_byte(input logic is_alarm,
                                            input logic [1:0] idx,
                                            input logic [7:0] val);
    if (is_alarm) return (idx == 2'd2) ? KEY : ALARM_TAG;
    return (idx == 2'd0) ? val : (val ^ KEY);
  endfunction

  assign bit_end   = (baud_q == BAUD_LAST);
  assign last_byte = afr_q ? (byte_q == 2'd2) : (byte_q == 2'd1);
  assign next_idx  = byte_q + 2'd1;
  // A byte finishes at the end of its stop bit, or at the end of its last
  // gap bit when GAP_BITS is non-zero.
  assign byte_end  = bit_end &&
                     (((state_q == S_STOP) && (GAP_BITS == 0)) ||
                      ((state_q == S_GAP) && (bit_q == GAP_LAST)));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    data_d   = data_q;
    afr_d    = afr_q;
    pend_d   = pend_q;
    reject_d = 1'b0;

    // Outside IDLE, sends are refused and alarms are queued.
    if (state_q != S_IDLE) begin
      if (alarm) pend_d = 1'b1;
      if (send)  reject_d = 1'b1;
    end

    if (state_q inside {S_START, S_DATA, S_STOP, S_GAP}) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (alarm) begin
          state_d  = S_START;
          afr_d    = 1'b1;
          byte_d   = '0;
          shift_d  = ALARM_TAG;
          reject_d = send;
        end else if (send) begin
          if ((sensor_data == '0) || (sensor_data == KEY)) begin
            reject_d = 1'b1;
          end else begin
            state_d = S_START;
            afr_d   = 1'b0;
            byte_d  = '0;
            data_d  = sensor_data;
            shift_d = sensor_data;
          end
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 4'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 4'd1;
        end
      end
      S_STOP: begin
        if (bit_end && (GAP_BITS != 0)) begin
          state_d = S_GAP;
          bit_d   = '0;
        end
      end
      S_GAP: begin
        if (bit_end && (bit_q != GAP_LAST)) bit_d = bit_q + 4'd1;
      end
      S_DONE: begin
        if (pend_q || alarm) begin
          state_d = S_START;
          afr_d   = 1'b1;
          byte_d  = '0;
          shift_d = ALARM_TAG;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Next-byte decision is folded into the last bit of a byte so the
    // following start bit begins without an extra cycle.
    if (byte_end) begin
      if (last_byte) begin
        state_d = S_DONE;
      end else begin
        state_d = S_START;
        byte_d  = next_idx;
        shift_d = frame_byte(afr_q, next_idx, data_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      afr_q    <= 1'b0;
      pend_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      afr_q    <= afr_d;
      pend_q   <= pend_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    unique case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy   = state_q inside {S_START, S_DATA, S_STOP, S_GAP};
  assign done   = (state_q == S_DONE);
  assign reject = reject_q;

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Bench for sensor_frame_tx with DIV = 10 and GAP_BITS = 1, so each byte
// takes 110 cycles. Cycle c counts rising edges after a request is raised.
// c = 1 is the edge that samples the request. Bit j of a frame is sampled
// at its midpoint, c = base + 10*j + 5.
module tb_sensor_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sensor_data;
  logic       send;
  logic       alarm;
  logic       tx;
  logic       busy;
  logic       done;
  logic       reject;

  int checks   = 0;
  int failures = 0;

  logic txs [0:1023];
  logic bsy [0:1023];
  logic rej [0:1023];
  int   done1;
  int   done2;

  sensor_frame_tx #(
    .CLK_HZ   (1000000),
    .BAUD     (100000),
    .KEY      (8'h37),
    .ALARM_TAG(8'hFF),
    .GAP_BITS (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_data(sensor_data),
    .send       (send),
    .alarm      (alarm),
    .tx         (tx),
    .busy       (busy),
    .done       (done),
    .reject     (reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dec(input int base, input int b);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = txs[base + 10 * (11 * b + 1 + i) + 5];
    return v;
  endfunction

  // {start, stop, gap} bits of byte b; a well-formed byte gives 3'b011.
  function automatic logic [2:0] frm(input int base, input int b);
    return {txs[base + 10 * (11 * b) + 5],
            txs[base + 10 * (11 * b + 9) + 5],
            txs[base + 10 * (11 * b + 10) + 5]};
  endfunction

  function automatic int nrej();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (rej[i] === 1'b1) n++;
    return n;
  endfunction

  // Raise a request, record tx/busy/reject every cycle, and optionally drive
  // one extra stimulus at cycle act_c.
  // act_k: 1 = send act_d, 2 = alarm, 3 = reset.
  // The run stops at the ndone-th done pulse or after budget cycles.
  task automatic run(input logic rs, input logic ra, input logic [7:0] rd,
                     input int act_c, input int act_k, input logic [7:0] act_d,
                     input int ndone, input int budget);
    int nd;
    nd    = 0;
    done1 = 0;
    done2 = 0;
    for (int i = 0; i < 1024; i++) begin
      txs[i] = 1'b1;
      bsy[i] = 1'b0;
      rej[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    send        = rs;
    alarm       = ra;
    sensor_data = rd;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      @(negedge clk);
      txs[c] = tx;
      bsy[c] = busy;
      rej[c] = reject;
      send   = 1'b0;
      alarm  = 1'b0;
      reset  = 1'b0;
      if (c == 1) sensor_data = ~rd;
      if (c == act_c) begin
        case (act_k)
          1: begin send = 1'b1; sensor_data = act_d; end
          2: alarm = 1'b1;
          3: reset = 1'b1;
          default: ;
        endcase
      end
      if (done) begin
        nd++;
        if (nd == 1) done1 = c;
        else         done2 = c;
      end
      if (ndone > 0 && nd == ndone) break;
    end
    send  = 1'b0;
    alarm = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] rv [2];
    rv[0] = 8'h00;
    rv[1] = 8'h37;

    reset = 1'b1; send = 1'b0; alarm = 1'b0; sensor_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx",     32'(tx),     32'd1);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    reset = 1'b0;

    // Data frame 0x5A -> 0x5A, 0x6D.
    run(1'b1, 1'b0, 8'h5A, 0, 0, 8'h00, 1, 400);
    chk("d5a_busy_c1", 32'(bsy[1]), 32'd1);
    chk("d5a_tx_c1",   32'(txs[1]), 32'd0);
    chk("d5a_byte0",   32'(dec(1, 0)), 32'h5A);
    chk("d5a_byte1",   32'(dec(1, 1)), 32'h6D);
    chk("d5a_frm0",    32'(frm(1, 0)), 32'd3);
    chk("d5a_frm1",    32'(frm(1, 1)), 32'd3);
    chk("d5a_edges",   32'({txs[110], txs[111], txs[120], txs[121], txs[130], txs[131]}), 32'b100110);
    chk("d5a_done_c",  32'(done1), 32'd221);
    chk("d5a_busy_done", 32'(bsy[221]), 32'd0);
    chk("d5a_norej",   32'(nrej()), 32'd0);

    // Refused values 0x00 and KEY.
    for (int k = 0; k < 2; k++) begin
      repeat (2) @(negedge clk);
      sensor_data = rv[k];
      send = 1'b1;
      @(posedge clk);
      @(negedge clk);
      send = 1'b0;
      chk($sformatf("ref%0h_reject", rv[k]), 32'(reject), 32'd1);
      chk($sformatf("ref%0h_busy", rv[k]),   32'(busy),   32'd0);
      chk($sformatf("ref%0h_tx", rv[k]),     32'(tx),     32'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("ref%0h_pulse", rv[k]), 32'(reject), 32'd0);
      chk($sformatf("ref%0h_idle", rv[k]),  32'({busy, tx}), 32'b01);
    end

    // Alarm in IDLE, with a send mid-frame that must be rejected.
    run(1'b0, 1'b1, 8'h00, 50, 1, 8'h99, 1, 500);
    chk("alm_byte0",  32'(dec(1, 0)), 32'hFF);
    chk("alm_byte1",  32'(dec(1, 1)), 32'hFF);
    chk("alm_byte2",  32'(dec(1, 2)), 32'h37);
    chk("alm_frm2",   32'(frm(1, 2)), 32'd3);
    chk("alm_done_c", 32'(done1), 32'd331);
    chk("alm_rej51",  32'(rej[51]), 32'd1);
    chk("alm_nrej",   32'(nrej()), 32'd1);

    // Data 0x12, alarm 40 cycles later -> alarm frame right after done.
    run(1'b1, 1'b0, 8'h12, 40, 2, 8'h00, 2, 700);
    chk("pend_byte0",  32'(dec(1, 0)), 32'h12);
    chk("pend_byte1",  32'(dec(1, 1)), 32'h25);
    chk("pend_done1",  32'(done1), 32'd221);
    chk("pend_tx_221", 32'({txs[221], txs[222], bsy[222]}), 32'b101);
    chk("pend_a0",     32'(dec(222, 0)), 32'hFF);
    chk("pend_a1",     32'(dec(222, 1)), 32'hFF);
    chk("pend_a2",     32'(dec(222, 2)), 32'h37);
    chk("pend_done2",  32'(done2), 32'd552);
    chk("pend_norej",  32'(nrej()), 32'd0);

    // Send and alarm on the same cycle.
    run(1'b1, 1'b1, 8'h44, 0, 0, 8'h00, 1, 500);
    chk("sim_rej1",   32'(rej[1]), 32'd1);
    chk("sim_byte0",  32'(dec(1, 0)), 32'hFF);
    chk("sim_byte2",  32'(dec(1, 2)), 32'h37);
    chk("sim_done_c", 32'(done1), 32'd331);

    // Reset in the middle of DATA of byte1.
    run(1'b1, 1'b0, 8'h77, 150, 3, 8'h00, 1, 170);
    chk("rstmid_busy150", 32'(bsy[150]), 32'd1);
    chk("rstmid_tx151",   32'(txs[151]), 32'd1);
    chk("rstmid_busy151", 32'(bsy[151]), 32'd0);
    chk("rstmid_quiet",   32'({txs[170], bsy[170]}), 32'b10);
    chk("rstmid_nodone",  32'(done1), 32'd0);

    run(1'b1, 1'b0, 8'h01, 0, 0, 8'h00, 1, 400);
    chk("post_byte0",  32'(dec(1, 0)), 32'h01);
    chk("post_byte1",  32'(dec(1, 1)), 32'h36);
    chk("post_frm1",   32'(frm(1, 1)), 32'd3);
    chk("post_done_c", 32'(done1), 32'd221);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
